// File: rtl/pulse_util_pkg.sv
// Shared types and helpers for the pulse stretcher and related event-shaping blocks.
package pulse_util_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StGap
  } state_e;

  function automatic int unsigned max(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down counter with synchronous clear; simultaneous inc and dec cancel.
module pend_counter #(
  parameter int unsigned MAX = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       inc_i,
  input  logic                       dec_i,
  output logic [$clog2(MAX+1)-1:0]   count_o,
  output logic                       sat_o
);

  localparam int unsigned W = $clog2(MAX + 1);
  localparam logic [W-1:0] CntMax = W'(MAX);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = (count_q == CntMax);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle pulses into WIDTH-cycle windows separated by at least GAP low cycles.
// Define PULSE_STRETCHER_RETRIGGER_EN to replace queueing with window retriggering.
module pulse_stretcher
  import pulse_util_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned GAP      = 2,
  parameter int unsigned MAX_PEND = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            pulse_i,
  input  logic                            clear_i,
  output logic                            level_o,
  output logic                            done_o,
  output logic [$clog2(MAX_PEND+1)-1:0]   pend_o,
  output logic                            overflow_o
);

  localparam int unsigned CntW  = $clog2(max(WIDTH, GAP) + 1);
  localparam int unsigned PendW = $clog2(MAX_PEND + 1);

  localparam logic [CntW-1:0] WidthLoad = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'((GAP > 0) ? GAP - 1 : 0);

  state_e          state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            level_d, done_d, ovf_d, ovf_q;

`ifndef PULSE_STRETCHER_RETRIGGER_EN
  logic             pend_inc, pend_dec, pend_sat, pend_nz;
  logic [PendW-1:0] pend_cnt;

  pend_counter #(
    .MAX (MAX_PEND)
  ) u_pend_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clear_i),
    .inc_i   (pend_inc),
    .dec_i   (pend_dec),
    .count_o (pend_cnt),
    .sat_o   (pend_sat)
  );

  assign pend_nz = (pend_cnt != '0);
  assign pend_o  = pend_cnt;
`else
  assign pend_o  = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
`ifndef PULSE_STRETCHER_RETRIGGER_EN
    pend_inc = 1'b0;
    pend_dec = 1'b0;
`endif

    if (clear_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
`ifndef PULSE_STRETCHER_RETRIGGER_EN
          // A pulse left queued by a same-cycle arrival at window end is replayed from here.
          if (pend_nz) begin
            pend_dec = 1'b1;
            pend_inc = pulse_i;
          end
          if (pulse_i || pend_nz) begin
`else
          if (pulse_i) begin
`endif
            state_d = StHigh;
            cnt_d   = WidthLoad;
          end
        end

        StHigh: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
          if (pulse_i) begin
            cnt_d = WidthLoad;
          end else if (cnt_q == '0) begin
            done_d = 1'b1;
            if (GAP > 0) begin
              state_d = StGap;
              cnt_d   = GapLoad;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
`else
          pend_inc = pulse_i;
          if (cnt_q == '0) begin
            done_d = 1'b1;
            if (GAP > 0) begin
              state_d = StGap;
              cnt_d   = GapLoad;
            end else if (pend_nz) begin
              cnt_d    = WidthLoad;
              pend_dec = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
`endif
        end

        StGap: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
          if (pulse_i) begin
            ovf_d = 1'b1;
          end
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
`else
          pend_inc = pulse_i;
          if (cnt_q == '0) begin
            if (pend_nz) begin
              state_d  = StHigh;
              cnt_d    = WidthLoad;
              pend_dec = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
`endif
        end

        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase

`ifndef PULSE_STRETCHER_RETRIGGER_EN
      // Only a lone increment into a full queue loses a pulse.
      if (pend_inc && !pend_dec && pend_sat) begin
        ovf_d = 1'b1;
      end
`endif
    end

    level_d = (state_d == StHigh);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      level_o <= 1'b0;
      done_o  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_o <= level_d;
      done_o  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with WIDTH=4, GAP=2, MAX_PEND=3.
module tb_pulse_stretcher;

  logic       clk_i;
  logic       rst_ni;
  logic       pulse_i;
  logic       clear_i;
  logic       level_o;
  logic       done_o;
  logic [1:0] pend_o;
  logic       overflow_o;

  int checks = 0;
  int errors = 0;

  pulse_stretcher #(
    .WIDTH    (4),
    .GAP      (2),
    .MAX_PEND (3)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .pulse_i    (pulse_i),
    .clear_i    (clear_i),
    .level_o    (level_o),
    .done_o     (done_o),
    .pend_o     (pend_o),
    .overflow_o (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Abort whatever is running so each scenario starts from IDLE with empty queue.
  task automatic go_idle();
    @(posedge clk_i); #1;
    pulse_i = 1'b0;
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] ep;
    logic [4:0] exp;
    go_idle();
    // Pulses 2..6: windows at 3-6 and 9-12, pend saturates, overflow set.
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk_i); #1;
      pulse_i = (c >= 2 && c <= 6);
      @(negedge clk_i);
      ep = (c == 4) ? 2'd1 : (c == 5) ? 2'd2 : (c >= 6 && c <= 8) ? 2'd3 :
           (c >= 9) ? 2'd2 : 2'd0;
      exp = {(c >= 3 && c <= 6) || (c >= 9), c == 7, ep, c >= 7};
      checks++;
      if ({level_o, done_o, pend_o, overflow_o} !== exp) begin
        errors++;
        $display("FAIL reset_pre c=%0d got %b want %b (lvl,done,pend,ovf)", c,
                 {level_o, done_o, pend_o, overflow_o}, exp);
      end
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({level_o, done_o, pend_o, overflow_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async got %b want 00000", {level_o, done_o, pend_o, overflow_o});
    end
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      checks++;
      if ({level_o, done_o, pend_o, overflow_o} !== 5'b0) begin
        errors++;
        $display("FAIL reset_post c=%0d got %b want 00000", c,
                 {level_o, done_o, pend_o, overflow_o});
      end
    end
  endtask

`ifndef PULSE_STRETCHER_RETRIGGER_EN
  task automatic test_single();
    logic [4:0] exp;
    go_idle();
    // Second pulse lands in the first IDLE cycle after the gap.
    for (int c = 0; c < 28; c++) begin
      @(posedge clk_i); #1;
      pulse_i = (c == 10 || c == 17);
      @(negedge clk_i);
      exp = {(c >= 11 && c <= 14) || (c >= 18 && c <= 21), c == 15 || c == 22, 2'd0, 1'b0};
      checks++;
      if ({level_o, done_o, pend_o, overflow_o} !== exp) begin
        errors++;
        $display("FAIL single c=%0d got %b want %b (lvl,done,pend,ovf)", c,
                 {level_o, done_o, pend_o, overflow_o}, exp);
      end
    end
  endtask

  task automatic test_queue();
    logic [4:0] exp;
    go_idle();
    for (int c = 0; c < 26; c++) begin
      @(posedge clk_i); #1;
      pulse_i = (c == 10 || c == 12);
      @(negedge clk_i);
      exp = {(c >= 11 && c <= 14) || (c >= 17 && c <= 20), c == 15 || c == 21,
             (c >= 13 && c <= 16) ? 2'd1 : 2'd0, 1'b0};
      checks++;
      if ({level_o, done_o, pend_o, overflow_o} !== exp) begin
        errors++;
        $display("FAIL queue c=%0d got %b want %b (lvl,done,pend,ovf)", c,
                 {level_o, done_o, pend_o, overflow_o}, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [1:0] ep;
    logic [4:0] exp;
    go_idle();
    // Clear in cycle 36 (idle) must drop the sticky overflow flag.
    for (int c = 0; c < 39; c++) begin
      @(posedge clk_i); #1;
      pulse_i = (c >= 10 && c <= 14);
      clear_i = (c == 36);
      @(negedge clk_i);
      ep = (c == 12) ? 2'd1 : (c == 13) ? 2'd2 : (c >= 14 && c <= 16) ? 2'd3 :
           (c >= 17 && c <= 22) ? 2'd2 : (c >= 23 && c <= 28) ? 2'd1 : 2'd0;
      exp = {(c >= 11 && c <= 14) || (c >= 17 && c <= 20) || (c >= 23 && c <= 26) ||
             (c >= 29 && c <= 32),
             c == 15 || c == 21 || c == 27 || c == 33, ep, c >= 15 && c <= 36};
      checks++;
      if ({level_o, done_o, pend_o, overflow_o} !== exp) begin
        errors++;
        $display("FAIL overflow c=%0d got %b want %b (lvl,done,pend,ovf)", c,
                 {level_o, done_o, pend_o, overflow_o}, exp);
      end
    end
    clear_i = 1'b0;
  endtask

  task automatic test_clear();
    logic [4:0] exp;
    go_idle();
    // Pulse in cycle 12 coincides with clear and must be ignored.
    for (int c = 0; c < 22; c++) begin
      @(posedge clk_i); #1;
      pulse_i = (c >= 9 && c <= 12);
      clear_i = (c == 12);
      @(negedge clk_i);
      exp = {c >= 10 && c <= 12, 1'b0, (c == 11) ? 2'd1 : (c == 12) ? 2'd2 : 2'd0, 1'b0};
      checks++;
      if ({level_o, done_o, pend_o, overflow_o} !== exp) begin
        errors++;
        $display("FAIL clear c=%0d got %b want %b (lvl,done,pend,ovf)", c,
                 {level_o, done_o, pend_o, overflow_o}, exp);
      end
    end
    clear_i = 1'b0;
  endtask

  task automatic test_cancel();
    logic [4:0] exp;
    go_idle();
    // Pulse in cycle 16 meets the gap-end consumption of the queued pulse.
    for (int c = 0; c < 31; c++) begin
      @(posedge clk_i); #1;
      pulse_i = (c == 10 || c == 12 || c == 16);
      @(negedge clk_i);
      exp = {(c >= 11 && c <= 14) || (c >= 17 && c <= 20) || (c >= 23 && c <= 26),
             c == 15 || c == 21 || c == 27, (c >= 13 && c <= 22) ? 2'd1 : 2'd0, 1'b0};
      checks++;
      if ({level_o, done_o, pend_o, overflow_o} !== exp) begin
        errors++;
        $display("FAIL cancel c=%0d got %b want %b (lvl,done,pend,ovf)", c,
                 {level_o, done_o, pend_o, overflow_o}, exp);
      end
    end
  endtask
`else
  task automatic test_retrigger();
    logic [4:0] exp;
    go_idle();
    // Pulse 13 extends the window; pulse 19 lands in the gap and is dropped.
    for (int c = 0; c < 25; c++) begin
      @(posedge clk_i); #1;
      pulse_i = (c == 10 || c == 13 || c == 19);
      @(negedge clk_i);
      exp = {c >= 11 && c <= 17, c == 18, 2'd0, c >= 20};
      checks++;
      if ({level_o, done_o, pend_o, overflow_o} !== exp) begin
        errors++;
        $display("FAIL retrigger c=%0d got %b want %b (lvl,done,pend,ovf)", c,
                 {level_o, done_o, pend_o, overflow_o}, exp);
      end
    end
  endtask
`endif

  initial begin
    rst_ni  = 1'b0;
    pulse_i = 1'b0;
    clear_i = 1'b0;
    #2;
    checks++;
    if ({level_o, done_o, pend_o, overflow_o} !== 5'b0) begin
      errors++;
      $display("FAIL power_on_reset got %b want 00000", {level_o, done_o, pend_o, overflow_o});
    end
    #10 rst_ni = 1'b1;

    test_reset();
`ifndef PULSE_STRETCHER_RETRIGGER_EN
    test_single();
    test_queue();
    test_overflow();
    test_clear();
    test_cancel();
`else
    test_retrigger();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
